// File: rtl/venc1_rm.sv
// venc1_rm: rate matcher for the rate-1/3 coded stream.
// Each frame drops a fixed set of coded-bit indices, selected by the frame
// type, and passes the remaining bits through a single output register.
// Optional feature macro: VENC1_RM_CHK_EN. When it is defined, the block
// checks in_last against the frame length and exposes a sticky len_err flag.
module venc1_rm (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] hs_mode,
  input  logic       start,
  input  logic       in_vld,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       in_rdy,
  output logic       out_vld,
  output logic       out_bit,
  output logic       out_last,
  input  logic       out_rdy,
  output logic       done
`ifdef VENC1_RM_CHK_EN
  ,
  output logic       len_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Number of coded bits in a frame of the given type.
  function automatic logic [6:0] in_len(input logic [1:0] mode);
    logic [6:0] len;
    case (mode)
      2'b00:   len = 7'd48;
      2'b01:   len = 7'd111;
      2'b10:   len = 7'd90;
      default: len = 7'd48;
    endcase
    return len;
  endfunction

  // Number of rate-matched bits in a frame of the given type.
  function automatic logic [6:0] out_len(input logic [1:0] mode);
    logic [6:0] len;
    case (mode)
      2'b00:   len = 7'd40;
      2'b01:   len = 7'd80;
      2'b10:   len = 7'd60;
      default: len = 7'd40;
    endcase
    return len;
  endfunction

  // Puncturing pattern, part1 frames.
  function automatic logic punct_part1(input logic [6:0] idx);
    logic p;
    case (idx)
      7'd0, 7'd1, 7'd3, 7'd7, 7'd41, 7'd44, 7'd46, 7'd47: p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  // Puncturing pattern, part2 frames.
  function automatic logic punct_part2(input logic [6:0] idx);
    logic p;
    case (idx)
      7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7,
      7'd11, 7'd13, 7'd14, 7'd23,
      7'd41, 7'd47, 7'd53, 7'd56, 7'd59, 7'd65, 7'd68,
      7'd95, 7'd98, 7'd100, 7'd101,
      7'd103, 7'd104, 7'd105, 7'd106, 7'd107, 7'd108, 7'd109, 7'd110: p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  // Puncturing pattern, agch frames.
  function automatic logic punct_agch(input logic [6:0] idx);
    logic p;
    case (idx)
      7'd0, 7'd1, 7'd4, 7'd5, 7'd6, 7'd10, 7'd11, 7'd13, 7'd14, 7'd16,
      7'd22, 7'd23, 7'd30, 7'd36, 7'd43, 7'd46, 7'd60, 7'd62, 7'd63, 7'd70,
      7'd71, 7'd74, 7'd76, 7'd79, 7'd82, 7'd83, 7'd84, 7'd86, 7'd87, 7'd89: p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  // True when coded bit idx of a frame of the given type is dropped.
  function automatic logic is_punct(input logic [1:0] mode, input logic [6:0] idx);
    logic p;
    case (mode)
      2'b00:   p = punct_part1(idx);
      2'b01:   p = punct_part2(idx);
      2'b10:   p = punct_agch(idx);
      default: p = 1'b1;
    endcase
    return p;
  endfunction

  state_t     state_q,    state_d;
  logic [1:0] mode_q,     mode_d;
  logic [6:0] in_idx_q,   in_idx_d;
  logic [6:0] out_cnt_q,  out_cnt_d;
  logic       out_vld_q,  out_vld_d;
  logic       out_bit_q,  out_bit_d;
  logic       out_last_q, out_last_d;
  logic       done_q,     done_d;
  logic       in_rdy_s;
  logic       accept_s;
  logic       start_ok_s;
  logic       last_idx_s;

`ifdef VENC1_RM_CHK_EN
  logic       len_err_q,  len_err_d;
`else
  // in_last carries no meaning without the length checker.
  logic       unused_in_last_s;
  assign unused_in_last_s = in_last;
`endif

  assign start_ok_s = start && (hs_mode != 2'b11);
  assign last_idx_s = (in_idx_q == (in_len(mode_q) - 7'd1));
  assign accept_s   = in_vld && in_rdy_s;

  // Next-state, handshake and output-register update logic.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    in_idx_d   = in_idx_q;
    out_cnt_d  = out_cnt_q;
    out_bit_d  = out_bit_q;
    out_last_d = out_last_q;
    done_d     = 1'b0;
    in_rdy_s   = 1'b0;

    // Downstream take empties the output register unless it is reloaded below.
    if (out_vld_q && out_rdy) begin
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end else begin
      out_vld_d  = out_vld_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) begin
          mode_d    = hs_mode;
          in_idx_d  = 7'd0;
          out_cnt_d = 7'd0;
          state_d   = ST_RUN;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_RUN: begin
        // One output register: accept whenever it is empty or being emptied.
        in_rdy_s = !out_vld_q || out_rdy;
        if (accept_s) begin
          if (!is_punct(mode_q, in_idx_q)) begin
            out_vld_d  = 1'b1;
            out_bit_d  = in_bit;
            out_last_d = (out_cnt_q == (out_len(mode_q) - 7'd1));
            out_cnt_d  = out_cnt_q + 7'd1;
          end else begin
            out_cnt_d  = out_cnt_q;
          end
          in_idx_d = in_idx_q + 7'd1;
          if (last_idx_s) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!out_vld_q || out_rdy) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; rst discards any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= 2'b00;
      in_idx_q   <= 7'd0;
      out_cnt_q  <= 7'd0;
      out_vld_q  <= 1'b0;
      out_bit_q  <= 1'b0;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      in_idx_q   <= in_idx_d;
      out_cnt_q  <= out_cnt_d;
      out_vld_q  <= out_vld_d;
      out_bit_q  <= out_bit_d;
      out_last_q <= out_last_d;
      done_q     <= done_d;
    end
  end

`ifdef VENC1_RM_CHK_EN
  // Sticky length check: in_last must coincide exactly with the final index.
  always_comb begin
    len_err_d = len_err_q;
    if ((state_q == ST_IDLE) && start_ok_s) begin
      len_err_d = 1'b0;
    end else if ((state_q == ST_RUN) && accept_s && (in_last != last_idx_s)) begin
      len_err_d = 1'b1;
    end else begin
      len_err_d = len_err_q;
    end
  end

  // Length-error flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= len_err_d;
    end
  end

  assign len_err = len_err_q;
`endif

  assign in_rdy   = in_rdy_s;
  assign out_vld  = out_vld_q;
  assign out_bit  = out_bit_q;
  assign out_last = out_last_q;
  assign done     = done_q;

endmodule
